// File: rtl/mux_sequencer.sv
// Time-multiplexes a one-hot switch bank across the enabled channels: break-before-make
// guard, settle blanking, then an integration window gated to the correlator per channel.
module mux_sequencer #(
    parameter int MUX_LINES     = 8,
    parameter int DWELL_WIDTH   = 24,
    parameter int GUARD_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [MUX_LINES-1:0]         cfg_mask,
    input  logic [DWELL_WIDTH-1:0]       cfg_dwell,
    input  logic                         cfg_load,
    input  logic                         readout_ack,
    output logic [MUX_LINES-1:0]         mux_out,
    output logic [$clog2(MUX_LINES)-1:0] mux_sel,
    output logic                         integrate,
    output logic                         frame_done,
    output logic                         busy
);

    localparam int SEL_W = $clog2(MUX_LINES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BREAK   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_DWELL   = 3'd3,
        ST_READOUT = 3'd4
    } state_t;

    // Returns {found, index} of the first set bit strictly after sel, wrapping to 0;
    // sel itself is the last candidate so a single-bit mask maps back onto itself.
    function automatic logic [SEL_W:0] next_chan(input logic [MUX_LINES-1:0] mask,
                                                 input logic [SEL_W-1:0]     sel);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = {(SEL_W+1){1'b0}};
        for (int i = MUX_LINES; i >= 1; i--) begin
            idx = SEL_W'((int'(sel) + i) % MUX_LINES);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [MUX_LINES-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [MUX_LINES-1:0] one;
        one = {{(MUX_LINES-1){1'b0}}, 1'b1};
        return one << sel;
    endfunction

    state_t                 state_r, state_s;
    logic [DWELL_WIDTH-1:0] cnt_r, cnt_s;
    logic [MUX_LINES-1:0]   mask_r, pend_mask_r, eff_mask_s;
    logic [DWELL_WIDTH-1:0] dwell_r, pend_dwell_r, eff_dwell_s;
    logic                   pend_r;
    logic                   apply_s;
    logic [SEL_W:0]         nxt_s, first_s;
    logic [MUX_LINES-1:0]   mux_out_r, mux_out_s;
    logic [SEL_W-1:0]       mux_sel_r, mux_sel_s;
    logic                   integrate_r, integrate_s;
    logic                   frame_done_r, frame_done_s;
    logic                   busy_r, busy_s;

    assign first_s = next_chan(mask_r, SEL_W'(MUX_LINES - 1));
    assign nxt_s   = next_chan(eff_mask_s, mux_sel_r);

    // Effective config at a frame boundary: a load in this very cycle beats the pending buffer.
    always_comb begin
        eff_mask_s  = mask_r;
        eff_dwell_s = dwell_r;
        if (cfg_load) begin
            eff_mask_s  = cfg_mask;
            eff_dwell_s = cfg_dwell;
        end else if (pend_r) begin
            eff_mask_s  = pend_mask_r;
            eff_dwell_s = pend_dwell_r;
        end else begin
            eff_mask_s  = mask_r;
            eff_dwell_s = dwell_r;
        end
    end

    // Next-state and next-output logic; outputs are registered alongside the state.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        mux_sel_s    = mux_sel_r;
        mux_out_s    = mux_out_r;
        integrate_s  = 1'b0;
        frame_done_s = 1'b0;
        busy_s       = 1'b1;
        apply_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s    = 1'b0;
                mux_out_s = {MUX_LINES{1'b0}};
                if (enable && (mask_r != {MUX_LINES{1'b0}}) && (dwell_r != {DWELL_WIDTH{1'b0}})) begin
                    state_s   = ST_BREAK;
                    mux_sel_s = first_s[SEL_W-1:0];
                    cnt_s     = {DWELL_WIDTH{1'b0}};
                    busy_s    = 1'b1;
                end else begin
                    cnt_s = {DWELL_WIDTH{1'b0}};
                end
            end
            ST_BREAK: begin
                mux_out_s = {MUX_LINES{1'b0}};
                if (cnt_r == DWELL_WIDTH'(GUARD_CYCLES - 1)) begin
                    state_s   = ST_SETTLE;
                    cnt_s     = {DWELL_WIDTH{1'b0}};
                    mux_out_s = onehot(mux_sel_r);
                end else begin
                    cnt_s = cnt_r + DWELL_WIDTH'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_r == DWELL_WIDTH'(SETTLE_CYCLES - 1)) begin
                    state_s     = ST_DWELL;
                    cnt_s       = {DWELL_WIDTH{1'b0}};
                    integrate_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + DWELL_WIDTH'(1);
                end
            end
            ST_DWELL: begin
                if (cnt_r == (dwell_r - DWELL_WIDTH'(1))) begin
                    state_s      = ST_READOUT;
                    cnt_s        = {DWELL_WIDTH{1'b0}};
                    frame_done_s = 1'b1;
                end else begin
                    cnt_s       = cnt_r + DWELL_WIDTH'(1);
                    integrate_s = 1'b1;
                end
            end
            ST_READOUT: begin
                if (readout_ack) begin
                    apply_s = 1'b1;
                    cnt_s   = {DWELL_WIDTH{1'b0}};
                    if (!nxt_s[SEL_W] || (eff_dwell_s == {DWELL_WIDTH{1'b0}})) begin
                        state_s   = ST_IDLE;
                        mux_out_s = {MUX_LINES{1'b0}};
                        busy_s    = 1'b0;
                    end else if (nxt_s[SEL_W-1:0] == mux_sel_r) begin
                        state_s     = ST_DWELL;
                        integrate_s = 1'b1;
                    end else begin
                        state_s   = ST_BREAK;
                        mux_sel_s = nxt_s[SEL_W-1:0];
                        mux_out_s = {MUX_LINES{1'b0}};
                    end
                end else begin
                    state_s = ST_READOUT;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_s     = {DWELL_WIDTH{1'b0}};
                mux_out_s = {MUX_LINES{1'b0}};
                busy_s    = 1'b0;
            end
        endcase
        // Abort beats everything, ack included; pending config is folded in so it is not lost.
        if ((state_r != ST_IDLE) && !enable) begin
            state_s      = ST_IDLE;
            cnt_s        = {DWELL_WIDTH{1'b0}};
            mux_sel_s    = mux_sel_r;
            mux_out_s    = {MUX_LINES{1'b0}};
            integrate_s  = 1'b0;
            frame_done_s = 1'b0;
            busy_s       = 1'b0;
            apply_s      = 1'b1;
        end else begin
            state_s = state_s;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {DWELL_WIDTH{1'b0}};
            mux_out_r    <= {MUX_LINES{1'b0}};
            mux_sel_r    <= {SEL_W{1'b0}};
            integrate_r  <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            mux_out_r    <= mux_out_s;
            mux_sel_r    <= mux_sel_s;
            integrate_r  <= integrate_s;
            frame_done_r <= frame_done_s;
            busy_r       <= busy_s;
        end
    end

    // Shadow and pending configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r       <= {MUX_LINES{1'b0}};
            dwell_r      <= {DWELL_WIDTH{1'b0}};
            pend_r       <= 1'b0;
            pend_mask_r  <= {MUX_LINES{1'b0}};
            pend_dwell_r <= {DWELL_WIDTH{1'b0}};
        end else if ((state_r == ST_IDLE) && cfg_load) begin
            mask_r  <= cfg_mask;
            dwell_r <= cfg_dwell;
            pend_r  <= 1'b0;
        end else if (apply_s) begin
            mask_r  <= eff_mask_s;
            dwell_r <= eff_dwell_s;
            pend_r  <= 1'b0;
        end else if (cfg_load) begin
            pend_r       <= 1'b1;
            pend_mask_r  <= cfg_mask;
            pend_dwell_r <= cfg_dwell;
        end
    end

    assign mux_out    = mux_out_r;
    assign mux_sel    = mux_sel_r;
    assign integrate  = integrate_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule
